// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM-stage sequencer and its MEM/WB register.
package mem_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int WB_CTRL_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: load captures a full writeback record, bubble
// clears only the WB control so the remaining fields hold their last value.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 bubble,
    input  logic [WB_CTRL_W-1:0] ctrl_wb_in,
    input  logic [DATA_W-1:0]    rdata_in,
    input  logic [DATA_W-1:0]    alu_result_in,
    input  logic [REG_W-1:0]     rd_in,
    output logic [WB_CTRL_W-1:0] ctrl_wb_out,
    output logic [DATA_W-1:0]    mem_rdata_out,
    output logic [DATA_W-1:0]    alu_result_out,
    output logic [REG_W-1:0]     rd_out
);

    logic [WB_CTRL_W-1:0] ctrl_wb_q, ctrl_wb_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [DATA_W-1:0]    alu_q, alu_d;
    logic [REG_W-1:0]     rd_q, rd_d;

    always_comb begin
        ctrl_wb_d = ctrl_wb_q;
        rdata_d   = rdata_q;
        alu_d     = alu_q;
        rd_d      = rd_q;
        if (load) begin
            ctrl_wb_d = ctrl_wb_in;
            rdata_d   = rdata_in;
            alu_d     = alu_result_in;
            rd_d      = rd_in;
        end else if (bubble) begin
            ctrl_wb_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_wb_q <= '0;
            rdata_q   <= '0;
            alu_q     <= '0;
            rd_q      <= '0;
        end else begin
            ctrl_wb_q <= ctrl_wb_d;
            rdata_q   <= rdata_d;
            alu_q     <= alu_d;
            rd_q      <= rd_d;
        end
    end

    assign ctrl_wb_out    = ctrl_wb_q;
    assign mem_rdata_out  = rdata_q;
    assign alu_result_out = alu_q;
    assign rd_out         = rd_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: drives a req/ack data memory, stalls upstream while busy
// and feeds MEM/WB. Define MEM_TIMEOUT_EN to add the REQ timeout and timeout_err.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WB_CTRL_W-1:0] ctrl_wb_in,
    input  logic                 mem_read_in,
    input  logic                 mem_write_in,
    input  logic [DATA_W-1:0]    alu_result_in,
    input  logic [DATA_W-1:0]    wdata_in,
    input  logic [REG_W-1:0]     rd_in,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DATA_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic                 stall,
    output logic [WB_CTRL_W-1:0] ctrl_wb_out,
    output logic [DATA_W-1:0]    mem_rdata_out,
    output logic [DATA_W-1:0]    alu_result_out,
    output logic [REG_W-1:0]     rd_out
`ifdef MEM_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [DATA_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 wb_load, wb_bubble;
    logic [WB_CTRL_W-1:0] wb_ctrl;
    logic [DATA_W-1:0]    wb_rdata;
    logic                 access;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             kill_q, kill_d;
    logic             timeout_q, timeout_d;
`endif

    assign access = mem_read_in | mem_write_in;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wb_load   = 1'b0;
        wb_bubble = 1'b0;
        wb_ctrl   = ctrl_wb_in;
        wb_rdata  = '0;
        stall     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
        kill_d    = kill_q;
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                    addr_d    = alu_result_in;
                    wdata_d   = wdata_in;
                    // Both read and write set is illegal; it resolves to a write.
                    we_d      = mem_write_in;
                    req_d     = 1'b1;
                    state_d   = REQ;
`ifdef MEM_TIMEOUT_EN
                    cnt_d     = '0;
                    kill_d    = 1'b0;
`endif
                end else begin
                    wb_load = 1'b1;
                end
            end
            REQ: begin
                stall     = 1'b1;
                wb_bubble = 1'b1;
                if (dmem_ack) begin
                    rdata_d = we_q ? '0 : dmem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    kill_d    = 1'b1;
                    rdata_d   = '0;
                    req_d     = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                // The EX/MEM op is still presented here; retire it without re-issuing.
                wb_load  = 1'b1;
                wb_rdata = rdata_q;
`ifdef MEM_TIMEOUT_EN
                if (kill_q) begin
                    wb_ctrl = '0;
                end
`endif
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
            kill_q    <= 1'b0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            kill_q    <= kill_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
`ifdef MEM_TIMEOUT_EN
    assign timeout_err = timeout_q;
`endif

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb (
        .clk            (clk),
        .rst            (rst),
        .load           (wb_load),
        .bubble         (wb_bubble),
        .ctrl_wb_in     (wb_ctrl),
        .rdata_in       (wb_rdata),
        .alu_result_in  (alu_result_in),
        .rd_in          (rd_in),
        .ctrl_wb_out    (ctrl_wb_out),
        .mem_rdata_out  (mem_rdata_out),
        .alu_result_out (alu_result_out),
        .rd_out         (rd_out)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: per-instruction reference model plus directed cases.
// With MEM_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=8.
module tb_mem_stage_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ctrl_wb_in;
    logic        mem_read_in, mem_write_in;
    logic [31:0] alu_result_in, wdata_in;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [1:0]  ctrl_wb_out;
    logic [31:0] mem_rdata_out, alu_result_out;
    logic [4:0]  rd_out;
`ifdef MEM_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .DATA_W (32),
        .REG_W  (5)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_wb_in     (ctrl_wb_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .alu_result_in  (alu_result_in),
        .wdata_in       (wdata_in),
        .rd_in          (rd_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .stall          (stall),
        .ctrl_wb_out    (ctrl_wb_out),
        .mem_rdata_out  (mem_rdata_out),
        .alu_result_out (alu_result_out),
        .rd_out         (rd_out)
`ifdef MEM_TIMEOUT_EN
        , .timeout_err  (timeout_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Expected MEM/WB contents and sticky timeout flag
    logic [1:0]  exp_ctrl;
    logic [31:0] exp_rdata, exp_alu;
    logic [4:0]  exp_rd;
    logic        exp_to;
    logic        prev_req;
    int          op_id = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s op=%0d: got 0x%0h expected 0x%0h", name, op_id, act, exp);
        end
    endtask

    task automatic chk_mwb();
        chk("ctrl_wb_out", 32'(ctrl_wb_out), 32'(exp_ctrl));
        chk("mem_rdata_out", mem_rdata_out, exp_rdata);
        chk("alu_result_out", alu_result_out, exp_alu);
        chk("rd_out", 32'(rd_out), 32'(exp_rd));
`ifdef MEM_TIMEOUT_EN
        chk("timeout_err", 32'(timeout_err), 32'(exp_to));
`endif
    endtask

    // Presents one EX/MEM instruction until it retires. kind: 0 none, 1 load,
    // 2 store, 3 both (acts as store). ack_k: REQ cycle carrying ack (0 = never).
    task automatic run_op(input int kind, input logic [1:0] c, input logic [31:0] a,
                          input logic [31:0] w, input logic [4:0] r, input int ack_k,
                          input logic [31:0] rd_val,
                          output int n_stall, output int n_req, output int n_rise);
        bit          is_mem, is_wr, acked, done, killed;
        int          pres, reqc;
        logic [31:0] cap;
        is_mem = (kind != 0);
        is_wr  = (kind >= 2);
        acked = 0; done = 0; killed = 0; pres = 0; reqc = 0; cap = '0;
        n_stall = 0; n_req = 0; n_rise = 0;
        op_id++;
        ctrl_wb_in    = c;
        mem_read_in   = (kind == 1) || (kind == 3);
        mem_write_in  = (kind >= 2);
        alu_result_in = a;
        wdata_in      = w;
        rd_in         = r;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            bit e_req, e_stall, give_ack;
            e_req   = is_mem && pres >= 1 && !acked;
            e_stall = is_mem && !acked;
            if (e_req) begin
                reqc++;
                give_ack = (reqc == ack_k);
            end else begin
                give_ack = ($urandom_range(0, 3) == 0);
            end
            dmem_ack   = give_ack;
            dmem_rdata = (give_ack && e_req) ? rd_val : $urandom;
            #1;
            chk("stall", 32'(stall), 32'(e_stall));
            chk("dmem_req", 32'(dmem_req), 32'(e_req));
            if (e_req) begin
                chk("dmem_addr", dmem_addr, a);
                chk("dmem_we", 32'(dmem_we), 32'(is_wr));
                if (is_wr) chk("dmem_wdata", dmem_wdata, w);
            end
            if (stall) n_stall++;
            if (dmem_req) begin
                n_req++;
                if (!prev_req) n_rise++;
            end
            prev_req = dmem_req;
            @(posedge clk);
            if (!e_stall) begin
                exp_ctrl  = killed ? 2'b00 : c;
                exp_rdata = (is_mem && !is_wr) ? cap : 32'h0;
                exp_alu   = a;
                exp_rd    = r;
                done      = 1;
            end else begin
                exp_ctrl = 2'b00;
            end
            if (e_req && give_ack) begin
                acked = 1;
                cap   = rd_val;
            end
`ifdef MEM_TIMEOUT_EN
            else if (e_req && reqc == TO) begin
                acked  = 1;
                cap    = '0;
                killed = 1;
                exp_to = 1'b1;
            end
`endif
            pres++;
            @(negedge clk);
            chk_mwb();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL retire_budget op=%0d: got not-retired expected retired", op_id);
        end
        dmem_ack = 1'b0;
        $display("op %0d kind=%0d addr=0x%0h stall=%0d req=%0d", op_id, kind, a, n_stall, n_req);
    endtask

    task automatic idle_inputs();
        ctrl_wb_in = '0; mem_read_in = 0; mem_write_in = 0;
        alu_result_in = '0; wdata_in = '0; rd_in = '0;
        dmem_ack = 0; dmem_rdata = '0;
    endtask

    task automatic reset_model();
        exp_ctrl = '0; exp_rdata = '0; exp_alu = '0; exp_rd = '0;
        exp_to = 1'b0; prev_req = 1'b0;
    endtask

    initial begin
        int ns, nr, nf;
        idle_inputs();
        rst = 1'b1;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_dmem_req", 32'(dmem_req), 32'h0);
        chk("reset_dmem_we", 32'(dmem_we), 32'h0);
        chk("reset_dmem_addr", dmem_addr, 32'h0);
        chk_mwb();
        rst = 1'b0;

        // Non-memory op passes through in one cycle
        run_op(0, 2'b10, 32'h1234, 32'h0, 5'd5, 1, 32'h0, ns, nr, nf);
        chk("t1_stall_cycles", 32'(ns), 32'd0);
        chk("t1_ctrl", 32'(ctrl_wb_out), 32'h2);
        chk("t1_alu", alu_result_out, 32'h1234);
        chk("t1_rd", 32'(rd_out), 32'd5);

        // Load with ack on the third REQ cycle
        run_op(1, 2'b01, 32'h40, 32'h0, 5'd7, 3, 32'hDEADBEEF, ns, nr, nf);
        chk("t2_stall_cycles", 32'(ns), 32'd4);
        chk("t2_req_cycles", 32'(nr), 32'd3);
        chk("t2_rdata", mem_rdata_out, 32'hDEADBEEF);

        // Store with ack on the first REQ cycle
        run_op(2, 2'b00, 32'h80, 32'hCAFE, 5'd0, 1, 32'h5555, ns, nr, nf);
        chk("t3_stall_cycles", 32'(ns), 32'd2);
        chk("t3_req_cycles", 32'(nr), 32'd1);
        chk("t3_rdata", mem_rdata_out, 32'h0);

        // Back-to-back loads: one request each, results in order
        run_op(1, 2'b11, 32'h10, 32'h0, 5'd1, 2, 32'hAAAA0010, ns, nr, nf);
        chk("t4a_requests", 32'(nf), 32'd1);
        chk("t4a_rdata", mem_rdata_out, 32'hAAAA0010);
        run_op(1, 2'b11, 32'h14, 32'h0, 5'd2, 1, 32'hBBBB0014, ns, nr, nf);
        chk("t4b_requests", 32'(nf), 32'd1);
        chk("t4b_rdata", mem_rdata_out, 32'hBBBB0014);
        chk("t4b_rd", 32'(rd_out), 32'd2);

        // Illegal read+write resolves to a store
        run_op(3, 2'b01, 32'hC0, 32'h77, 5'd9, 2, 32'h1111, ns, nr, nf);
        chk("both_rdata", mem_rdata_out, 32'h0);

`ifdef MEM_TIMEOUT_EN
        run_op(1, 2'b11, 32'h100, 32'h0, 5'd3, 0, 32'h0, ns, nr, nf);
        chk("t6_timeout_err", 32'(timeout_err), 32'h1);
        chk("t6_ctrl", 32'(ctrl_wb_out), 32'h0);
        chk("t6_req_cycles", 32'(nr), 32'(TO));
        run_op(0, 2'b10, 32'h200, 32'h0, 5'd4, 1, 32'h0, ns, nr, nf);
        chk("t6_resume_ctrl", 32'(ctrl_wb_out), 32'h2);
`endif

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            run_op($urandom_range(0, 3), 2'($urandom), $urandom, $urandom, 5'($urandom),
                   $urandom_range(1, 5), $urandom, ns, nr, nf);
            if ($urandom_range(0, 1) == 1) chk("rand_requests", 32'(nf), 32'(nr > 0 ? 1 : 0));
        end

        // Reset while a load is waiting in REQ
        op_id++;
        ctrl_wb_in = 2'b11; mem_read_in = 1; mem_write_in = 0;
        alu_result_in = 32'h300; rd_in = 5'd6; dmem_ack = 0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t5_req_before_rst", 32'(dmem_req), 32'h1);
        idle_inputs();
        rst = 1'b1;
        reset_model();
        @(posedge clk);
        @(negedge clk);
        chk("t5_dmem_req", 32'(dmem_req), 32'h0);
        chk("t5_stall", 32'(stall), 32'h0);
        chk_mwb();
        rst = 1'b0;
        run_op(0, 2'b01, 32'h400, 32'h0, 5'd8, 1, 32'h0, ns, nr, nf);
        chk("t5_resume_alu", alu_result_out, 32'h400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
